noc_out_port_ctrl: RTL and testbench

//  Output-port controller that sits directly downstream of rr_arbiter in each router output port.

---
 rtl/noc_out_port_ctrl.sv | 163 ++++++++++++++++
 tb/tb_noc_out_port_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_out_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : noc_out_port_ctrl
// Description : Router output-port controller; requests the arbiter for head
//               flits, locks head-to-tail, and registers the selected flit.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_out_port_ctrl #(
  parameter int N_IN   = 2,
  parameter int FLIT_W = 34,
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [N_IN-1:0]          in_valid_i,
  input  logic [N_IN*FLIT_W-1:0]   in_flit_i,
  output logic [N_IN-1:0]          in_ready_o,
  output logic [N_IN-1:0]          req_o,
  input  logic [N_IN-1:0]          grant_i,
  output logic                     update_o,
  output logic                     out_valid_o,
  output logic [FLIT_W-1:0]        out_flit_o,
  input  logic                     out_ready_i,
  output logic                     locked_o,
  output logic [IDX_W-1:0]         lock_idx_o
);

  localparam logic [0:0] c_ST_IDLE   = 1'b0;
  localparam logic [0:0] c_ST_LOCKED = 1'b1;

  localparam logic [1:0] c_TYPE_HEAD = 2'b01;
  localparam logic [1:0] c_TYPE_TAIL = 2'b11;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [IDX_W-1:0]  r_lock_idx;
  logic [IDX_W-1:0]  w_lock_idx_nxt;
  logic              r_out_valid;
  logic [FLIT_W-1:0] r_out_flit;

  logic              w_accept;
  logic [N_IN-1:0]   w_req_raw;
  logic [N_IN-1:0]   w_req;
  logic [N_IN-1:0]   w_ready;
  logic              w_update;
  logic [FLIT_W-1:0] w_flit [N_IN];
  logic [IDX_W-1:0]  w_gnt_idx;
  logic              w_gnt_any;
  logic              w_pop;
  logic [IDX_W-1:0]  w_pop_idx;
  logic [FLIT_W-1:0] w_pop_flit;
  logic [1:0]        w_pop_type;

  // Only single (00) and head (01) flits may start a packet.
  for (genvar k = 0; k < N_IN; k++) begin : g_unpack
    assign w_flit[k]    = in_flit_i[k*FLIT_W +: FLIT_W];
    assign w_req_raw[k] = in_valid_i[k] && !w_flit[k][FLIT_W-1];
  end

  assign w_accept = !r_out_valid || out_ready_i;

  // Lowest set grant bit wins if the arbiter ever hands back more than one.
  always_comb begin
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      if (grant_i[k]) begin
        w_gnt_idx = IDX_W'(k);
        w_gnt_any = 1'b1;
      end
    end
  end

  assign w_pop_flit = w_flit[w_pop_idx];
  assign w_pop_type = w_pop_flit[FLIT_W-1 -: 2];

  // State register
  always_ff @(posedge clk) begin
    if (arst) begin
      r_state    <= c_ST_IDLE;
      r_lock_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_idx <= w_lock_idx_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_idx_nxt = r_lock_idx;
    case (r_state)
      c_ST_IDLE: begin
        if (w_pop && (w_pop_type == c_TYPE_HEAD)) begin
          w_state_nxt    = c_ST_LOCKED;
          w_lock_idx_nxt = w_pop_idx;
        end
      end
      c_ST_LOCKED: begin
        if (w_pop && (w_pop_type == c_TYPE_TAIL)) begin
          w_state_nxt    = c_ST_IDLE;
          w_lock_idx_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = c_ST_IDLE;
        w_lock_idx_nxt = '0;
      end
    endcase
  end

  // Output logic; all handshake outputs are held low while reset is asserted.
  always_comb begin
    w_req     = '0;
    w_ready   = '0;
    w_update  = 1'b0;
    w_pop     = 1'b0;
    w_pop_idx = r_lock_idx;
    if (!arst) begin
      case (r_state)
        c_ST_IDLE: begin
          w_req     = w_req_raw;
          w_pop_idx = w_gnt_idx;
          if (w_accept && w_gnt_any && w_req_raw[w_gnt_idx]) begin
            w_pop              = 1'b1;
            w_update           = 1'b1;
            w_ready[w_gnt_idx] = 1'b1;
          end
        end
        c_ST_LOCKED: begin
          if (w_accept && in_valid_i[r_lock_idx]) begin
            w_pop               = 1'b1;
            w_ready[r_lock_idx] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Single registered output stage; flit is held when the stage drains.
  always_ff @(posedge clk) begin
    if (arst) begin
      r_out_valid <= 1'b0;
      r_out_flit  <= '0;
    end else if (w_accept) begin
      r_out_valid <= w_pop;
      if (w_pop) begin
        r_out_flit <= w_pop_flit;
      end
    end
  end

  assign in_ready_o  = w_ready;
  assign req_o       = w_req;
  assign update_o    = w_update;
  assign out_valid_o = r_out_valid;
  assign out_flit_o  = r_out_flit;
  assign locked_o    = (r_state == c_ST_LOCKED);
  assign lock_idx_o  = r_lock_idx;

endmodule
`default_nettype wire

// File: tb/tb_noc_out_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_out_port_ctrl
// Description : Randomized bench for noc_out_port_ctrl against a packet-level
//               reference model with per-input flit queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_out_port_ctrl;

  localparam int N_IN   = 2;
  localparam int FLIT_W = 34;

  logic              clk = 1'b0;
  logic              arst;
  logic [1:0]        in_valid_i;
  logic [67:0]       in_flit_i;
  logic [1:0]        in_ready_o;
  logic [1:0]        req_o;
  logic [1:0]        grant_i;
  logic              update_o;
  logic              out_valid_o;
  logic [33:0]       out_flit_o;
  logic              out_ready_i;
  logic              locked_o;
  logic [0:0]        lock_idx_o;

  noc_out_port_ctrl #(.N_IN(N_IN), .FLIT_W(FLIT_W)) dut (
    .clk(clk), .arst(arst),
    .in_valid_i(in_valid_i), .in_flit_i(in_flit_i), .in_ready_o(in_ready_o),
    .req_o(req_o), .grant_i(grant_i), .update_o(update_o),
    .out_valid_o(out_valid_o), .out_flit_o(out_flit_o), .out_ready_i(out_ready_i),
    .locked_o(locked_o), .lock_idx_o(lock_idx_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: owning input (-1 = none), output register, arbiter pointer.
  int          m_owner = -1;
  logic        m_ov    = 1'b0;
  logic [33:0] m_of    = '0;
  int          rr_ptr  = 0;
  logic [33:0] q0[$];
  logic [33:0] q1[$];

  bit          rst_req, bubbles, ordy_rand, grant_fixed_en;
  logic        ordy_val;
  logic [1:0]  grant_fixed;
  int          upd_seen, lock_cycles, beats, pkts, seq;

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [33:0] qfront(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int k);
    if (k == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic qpush(input int k, input logic [33:0] f);
    if (k == 0) q0.push_back(f);
    else        q1.push_back(f);
  endtask

  task automatic push_pkt(input int k, input int nbody, input bit single);
    logic [31:0] tag;
    tag = 32'((k << 16) | seq);
    seq++;
    pkts++;
    if (single) begin
      qpush(k, {2'b00, tag});
    end else begin
      qpush(k, {2'b01, tag});
      for (int i = 0; i < nbody; i++) qpush(k, {2'b10, tag + 32'(i + 1) * 32'h100});
      qpush(k, {2'b11, tag ^ 32'h8000_0000});
    end
  endtask

  // One clock: drive at negedge, compare #1 later, then advance the model.
  task automatic cycle();
    logic [1:0]  v, req, rdy, gnt;
    logic        upd, acc, ordy;
    logic [33:0] f [2];
    logic [33:0] pf;
    int          g, pk;
    @(negedge clk);
    arst = rst_req;
    for (int k = 0; k < 2; k++) begin
      v[k] = (qsize(k) > 0) && (!bubbles || $urandom_range(3) != 0);
      f[k] = v[k] ? qfront(k) : {2'($urandom_range(3)), 32'($urandom)};
    end
    ordy = ordy_rand ? ($urandom_range(3) != 0) : ordy_val;
    acc  = !m_ov || ordy;
    req = '0; rdy = '0; upd = 1'b0; pk = -1; g = -1; pf = '0;
    gnt = grant_fixed_en ? grant_fixed : 2'($urandom_range(3));
    if (!rst_req) begin
      if (m_owner < 0) begin
        for (int k = 0; k < 2; k++) req[k] = v[k] && !f[k][33];
        if (!grant_fixed_en && $urandom_range(7) != 0) begin
          gnt = '0;
          if (req[rr_ptr])          gnt[rr_ptr] = 1'b1;
          else if (req[1 - rr_ptr]) gnt[1 - rr_ptr] = 1'b1;
        end
        g = gnt[0] ? 0 : (gnt[1] ? 1 : -1);
        if (acc && g >= 0 && req[g]) begin
          pk  = g;
          upd = 1'b1;
        end
      end else if (acc && v[m_owner]) begin
        pk = m_owner;
      end
    end
    if (pk >= 0) rdy[pk] = 1'b1;
    in_valid_i  = v;
    in_flit_i   = {f[1], f[0]};
    out_ready_i = ordy;
    grant_i     = gnt;
    #1;
    check("req_o", req_o, req);
    check("in_ready_o", in_ready_o, rdy);
    check("update_o", update_o, upd);
    check("out_valid_o", out_valid_o, m_ov);
    if (m_ov) check("out_flit_o", out_flit_o, m_of);
    check("locked_o", locked_o, m_owner >= 0);
    check("lock_idx_o", lock_idx_o, (m_owner >= 0) ? m_owner : 0);
    if (update_o) upd_seen++;
    if (locked_o) lock_cycles++;
    if (out_valid_o && ordy) beats++;
    if (rst_req) begin
      m_owner = -1; m_ov = 1'b0; m_of = '0;
      q0.delete(); q1.delete();
    end else begin
      if (pk >= 0) begin
        pf = f[pk];
        qpop(pk);
        if (m_owner < 0) begin
          if (pf[33:32] == 2'b01) m_owner = pk;
        end else if (pf[33:32] == 2'b11) begin
          m_owner = -1;
        end
      end
      if (upd) rr_ptr = (g + 1) % 2;
      if (acc) begin
        m_ov = (pk >= 0);
        if (pk >= 0) m_of = pf;
      end
    end
  endtask

  task automatic clear_counts();
    upd_seen = 0; lock_cycles = 0; beats = 0; pkts = 0;
  endtask

  initial begin
    arst = 1'b1; in_valid_i = '0; in_flit_i = '0; grant_i = '0; out_ready_i = 1'b1;
    rst_req = 1'b1; bubbles = 1'b0; ordy_rand = 1'b0; ordy_val = 1'b1;
    grant_fixed_en = 1'b1; grant_fixed = 2'b00; seq = 1;
    clear_counts();
    repeat (2) cycle();
    rst_req = 1'b0;

    // T1: single flit on in0.
    clear_counts();
    grant_fixed = 2'b01;
    push_pkt(0, 0, 1'b1);
    repeat (3) cycle();
    check("t1_updates", upd_seen, 1);
    check("t1_locked_cycles", lock_cycles, 0);
    check("t1_beats", beats, 1);

    // T2: four-flit packet on in1; locked from after the head pop through the tail pop.
    clear_counts();
    grant_fixed = 2'b10;
    push_pkt(1, 2, 1'b0);
    repeat (8) cycle();
    check("t2_updates", upd_seen, 1);
    check("t2_locked_cycles", lock_cycles, 3);
    check("t2_beats", beats, 4);

    // T3: randomized contention with a round-robin arbiter.
    clear_counts();
    grant_fixed_en = 1'b0; bubbles = 1'b1; ordy_rand = 1'b1;
    for (int i = 0; i < 40; i++) push_pkt($urandom_range(1), $urandom_range(3), $urandom_range(3) == 0);
    for (int i = 0; i < 4000 && (q0.size() != 0 || q1.size() != 0 || m_ov); i++) cycle();
    check("t3_drained", (q0.size() == 0 && q1.size() == 0 && !m_ov), 1);
    check("t3_updates", upd_seen, pkts);

    // T4: three-cycle downstream stall mid-packet.
    clear_counts();
    grant_fixed_en = 1'b1; grant_fixed = 2'b01; bubbles = 1'b0; ordy_rand = 1'b0; ordy_val = 1'b1;
    push_pkt(0, 4, 1'b0);
    repeat (3) cycle();
    ordy_val = 1'b0;
    repeat (3) cycle();
    ordy_val = 1'b1;
    repeat (8) cycle();
    check("t4_beats", beats, 6);
    check("t4_updates", upd_seen, 1);

    // T5: reset while locked, then a fresh packet on in1.
    clear_counts();
    push_pkt(0, 6, 1'b0);
    repeat (3) cycle();
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    grant_fixed = 2'b10;
    push_pkt(1, 1, 1'b0);
    repeat (6) cycle();
    check("t5_updates", upd_seen, 2);

    // T6: stray body flit while idle must stall unconsumed.
    clear_counts();
    grant_fixed = 2'b01;
    qpush(0, {2'b10, 32'hBAD0_0001});
    repeat (4) cycle();
    check("t6_updates", upd_seen, 0);
    check("t6_beats", beats, 0);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    repeat (2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
